// File: rtl/etx_tx_arbiter.sv
// etx_tx_arbiter: flushes the Ethernet TX FIFO on enable, then grants whole frames
// round-robin among NREQ sources and streams their 64-bit words into the FIFO.
module etx_tx_arbiter #(
    parameter int NREQ    = 2,
    parameter int HDR_LEN = 20,
    parameter int GAP_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 etx_full,
    input  logic                 etx_empty,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*16-1:0]   req_len,
    input  logic [NREQ-1:0]      src_valid,
    input  logic [NREQ*64-1:0]   src_data,
    output logic [NREQ-1:0]      src_ready,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      done,
    output logic                 busy,
    output logic                 etx_fifo_rst,
    output logic                 etx_enable,
    output logic                 ewr_en,
    output logic [63:0]          etx_din,
    output logic [15:0]          tx_data_length,
    output logic [15:0]          tx_total_length
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_ARB   = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t             state_r;
    logic [IW-1:0]      rr_ptr_r;
    logic [IW-1:0]      gidx_r;
    logic [12:0]        words_r;
    logic [15:0]        gap_cnt_r;
    logic [NREQ-1:0]    grant_r;
    logic [NREQ-1:0]    done_r;
    logic               busy_r;
    logic               fifo_rst_r;
    logic               enable_r;
    logic               ewr_en_r;
    logic [63:0]        din_r;
    logic [15:0]        data_len_r;
    logic [15:0]        total_len_r;

    logic               pick_ok_s;
    logic [IW-1:0]      pick_idx_s;
    logic [NREQ-1:0]    pick_onehot_s;
    logic [15:0]        pick_len_s;
    logic [12:0]        pick_words_s;
    logic [NREQ-1:0]    src_ready_s;
    logic               hs_s;
    logic [63:0]        sel_data_s;
    logic [IW-1:0]      rr_next_s;

    // Round-robin pick, frame size in words, and the combinational ready/handshake.
    always_comb begin
        int c;
        c          = 0;
        pick_ok_s  = 1'b0;
        pick_idx_s = {IW{1'b0}};
        // Walk from the farthest candidate back to rr_ptr so the nearest one wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            c          = (int'(rr_ptr_r) + k) % NREQ;
            pick_ok_s  = req[IW'(c)] ? 1'b1 : pick_ok_s;
            pick_idx_s = req[IW'(c)] ? IW'(c) : pick_idx_s;
        end
        if (pick_ok_s) begin
            pick_onehot_s = NREQ'(1'b1) << pick_idx_s;
        end else begin
            pick_onehot_s = {NREQ{1'b0}};
        end
        pick_len_s   = req_len[pick_idx_s*16 +: 16];
        pick_words_s = 13'(({1'b0, pick_len_s} + 17'd7) >> 3);
        if (state_r == ST_SEND && !etx_full) begin
            src_ready_s = grant_r;
        end else begin
            src_ready_s = {NREQ{1'b0}};
        end
        hs_s       = src_valid[gidx_r] & src_ready_s[gidx_r];
        sel_data_s = src_data[gidx_r*64 +: 64];
        if (gidx_r == IW'(NREQ - 1)) begin
            rr_next_s = {IW{1'b0}};
        end else begin
            rr_next_s = gidx_r + IW'(1'b1);
        end
    end

    // Frame sequencer: flush, arbitrate, stream words, pulse done, then pace the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {IW{1'b0}};
            gidx_r      <= {IW{1'b0}};
            words_r     <= 13'd0;
            gap_cnt_r   <= 16'd0;
            grant_r     <= {NREQ{1'b0}};
            done_r      <= {NREQ{1'b0}};
            busy_r      <= 1'b0;
            fifo_rst_r  <= 1'b0;
            enable_r    <= 1'b0;
            ewr_en_r    <= 1'b0;
            din_r       <= 64'd0;
            data_len_r  <= 16'd0;
            total_len_r <= 16'd0;
        end else if (!en) begin
            // Abort: the current frame is abandoned without a done pulse.
            state_r    <= ST_IDLE;
            grant_r    <= {NREQ{1'b0}};
            done_r     <= {NREQ{1'b0}};
            busy_r     <= 1'b0;
            fifo_rst_r <= 1'b0;
            enable_r   <= 1'b0;
            ewr_en_r   <= 1'b0;
        end else begin
            ewr_en_r <= 1'b0;
            done_r   <= {NREQ{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_FLUSH;
                    fifo_rst_r <= !etx_empty;
                    busy_r     <= 1'b1;
                end
                ST_FLUSH: begin
                    if (etx_empty) begin
                        state_r    <= ST_ARB;
                        fifo_rst_r <= 1'b0;
                        enable_r   <= 1'b1;
                        busy_r     <= 1'b0;
                    end else begin
                        fifo_rst_r <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (pick_ok_s) begin
                        grant_r     <= pick_onehot_s;
                        gidx_r      <= pick_idx_s;
                        words_r     <= pick_words_s;
                        data_len_r  <= pick_len_s;
                        total_len_r <= pick_len_s + 16'(HDR_LEN);
                        busy_r      <= 1'b1;
                        if (pick_words_s != 13'd0) begin
                            state_r <= ST_SEND;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= pick_onehot_s;
                        end
                    end else begin
                        grant_r <= {NREQ{1'b0}};
                    end
                end
                ST_SEND: begin
                    if (hs_s) begin
                        din_r    <= sel_data_s;
                        ewr_en_r <= 1'b1;
                        words_r  <= words_r - 13'd1;
                        if (words_r == 13'd1) begin
                            state_r <= ST_DONE;
                            done_r  <= grant_r;
                        end
                    end
                end
                ST_DONE: begin
                    grant_r  <= {NREQ{1'b0}};
                    rr_ptr_r <= rr_next_s;
                    if (GAP_CYC > 0) begin
                        state_r   <= ST_GAP;
                        gap_cnt_r <= 16'(GAP_CYC - 1);
                    end else begin
                        state_r <= ST_ARB;
                        busy_r  <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == 16'd0) begin
                        state_r <= ST_ARB;
                        busy_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= {NREQ{1'b0}};
                    busy_r     <= 1'b0;
                    fifo_rst_r <= 1'b0;
                    enable_r   <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready       = src_ready_s;
    assign grant           = grant_r;
    assign done            = done_r;
    assign busy            = busy_r;
    assign etx_fifo_rst    = fifo_rst_r;
    assign etx_enable      = enable_r;
    assign ewr_en          = ewr_en_r;
    assign etx_din         = din_r;
    assign tx_data_length  = data_len_r;
    assign tx_total_length = total_len_r;

endmodule

// File: tb/tb_etx_tx_arbiter.sv
// Scoreboard bench for etx_tx_arbiter: stimulus pushes expected FIFO writes and done
// pulses into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_etx_tx_arbiter;
    localparam int NREQ    = 2;
    localparam int HDR_LEN = 20;
    localparam int GAP_CYC = 2;

    logic                 clk = 1'b0;
    logic                 rst, en, etx_full, etx_empty;
    logic [NREQ-1:0]      req, src_valid, src_ready, grant, done;
    logic [NREQ*16-1:0]   req_len;
    logic [NREQ*64-1:0]   src_data;
    logic                 busy, etx_fifo_rst, etx_enable, ewr_en;
    logic [63:0]          etx_din;
    logic [15:0]          tx_data_length, tx_total_length;

    etx_tx_arbiter #(.NREQ(NREQ), .HDR_LEN(HDR_LEN), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .en(en), .etx_full(etx_full), .etx_empty(etx_empty),
        .req(req), .req_len(req_len), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .grant(grant), .done(done), .busy(busy),
        .etx_fifo_rst(etx_fifo_rst), .etx_enable(etx_enable), .ewr_en(ewr_en),
        .etx_din(etx_din), .tx_data_length(tx_data_length), .tx_total_length(tx_total_length)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] g;
        logic [15:0]     dl;
        logic [15:0]     tl;
    } done_t;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          fifo_cnt = 0;
    int          xfer_cnt = 0;
    int          frames [NREQ];
    logic [63:0] exp_wr_q [$];
    done_t       exp_done_q [$];
    int          wr_cyc_q [$];
    logic [63:0] src_q0 [$];
    logic [63:0] src_q1 [$];
    logic [NREQ-1:0] hs_smp, dn_smp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive();
        req[0]          = frames[0] > 0;
        req[1]          = frames[1] > 0;
        src_valid[0]    = src_q0.size() > 0;
        src_valid[1]    = src_q1.size() > 0;
        src_data[63:0]  = (src_q0.size() > 0) ? src_q0[0] : 64'd0;
        src_data[127:64] = (src_q1.size() > 0) ? src_q1[0] : 64'd0;
    endtask

    task automatic exp_done(input logic [NREQ-1:0] g, input logic [15:0] dl, input logic [15:0] tl);
        exp_done_q.push_back('{g: g, dl: dl, tl: tl});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_wr_q.size() != 0 || exp_done_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_wr_q.size() == 0 && exp_done_q.size() == 0) passes++;
        else $display("FAIL %s: %0d writes and %0d done pulses outstanding, expected 0",
                      name, exp_wr_q.size(), exp_done_q.size());
        exp_wr_q.delete();
        exp_done_q.delete();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!rst && etx_fifo_rst === 1'b1) fifo_cnt <= fifo_cnt + 1;

    // Monitor: compare every FIFO write and done pulse against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst && ewr_en === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            if (exp_wr_q.size() == 0) begin
                checks++;
                $display("FAIL extra_write: got %h expected no write", etx_din);
            end else begin
                chk("write_data", etx_din, exp_wr_q.pop_front());
            end
        end
        if (!rst && done !== {NREQ{1'b0}}) begin
            if (exp_done_q.size() == 0) begin
                checks++;
                $display("FAIL extra_done: got %b expected no pulse", done);
            end else begin
                done_t e;
                e = exp_done_q.pop_front();
                chk("done_vec", 64'(done), 64'(e.g));
                chk("done_grant", 64'(grant), 64'(e.g));
                chk("data_len", 64'(tx_data_length), 64'(e.dl));
                chk("total_len", 64'(tx_total_length), 64'(e.tl));
            end
        end
    end

    // Source model: consume accepted words and retire a frame request on its done pulse.
    always begin
        @(negedge clk);
        hs_smp = src_valid & src_ready;
        dn_smp = done;
        @(posedge clk);
        #1;
        if (hs_smp[0] === 1'b1) begin void'(src_q0.pop_front()); xfer_cnt++; end
        if (hs_smp[1] === 1'b1) begin void'(src_q1.pop_front()); xfer_cnt++; end
        if (dn_smp[0] === 1'b1 && frames[0] > 0) frames[0]--;
        if (dn_smp[1] === 1'b1 && frames[1] > 0) frames[1]--;
        drive();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; en = 1'b0; etx_full = 1'b0; etx_empty = 1'b1;
        req_len = '0; frames[0] = 0; frames[1] = 0;
        drive();
        repeat (3) tick();
        chk("rst_ctrl", 64'({grant, done, src_ready, busy, etx_fifo_rst, etx_enable, ewr_en}), 64'd0);
        chk("rst_din", etx_din, 64'd0);
        chk("rst_len", 64'({tx_data_length, tx_total_length}), 64'd0);

        // Flush: FIFO reports non-empty for 3 cycles from enable.
        rst = 1'b0; en = 1'b1; etx_empty = 1'b0;
        repeat (3) tick();
        chk("flush_no_enable", 64'(etx_enable), 64'd0);
        etx_empty = 1'b1;
        tick();
        chk("flush_rst_cycles", 64'(fifo_cnt), 64'd3);
        chk("arb_state", 64'({etx_enable, etx_fifo_rst, busy, grant}), 64'({1'b1, 1'b0, 1'b0, 2'b00}));

        // Single 24-byte frame from source 0.
        req_len[15:0] = 16'd24;
        src_q0 = '{64'hA0A0_0000_0000_0001, 64'hB0B0_0000_0000_0002, 64'hC0C0_0000_0000_0003};
        exp_wr_q = '{64'hA0A0_0000_0000_0001, 64'hB0B0_0000_0000_0002, 64'hC0C0_0000_0000_0003};
        exp_done(2'b01, 16'd24, 16'd44);
        frames[0] = 1; wr_cyc_q.delete(); drive();
        wait_drain("frame24", 40);
        chk("frame24_writes", 64'(wr_cyc_q.size()), 64'd3);
        if (wr_cyc_q.size() == 3) chk("frame24_back2back", 64'(wr_cyc_q[2] - wr_cyc_q[0]), 64'd2);
        repeat (4) tick();
        chk("frame24_len_hold", 64'({tx_data_length, tx_total_length}), 64'({16'd24, 16'd44}));
        chk("idle_grant", 64'(grant), 64'd0);

        // Zero-length frame on source 1.
        req_len[31:16] = 16'd0;
        exp_done(2'b10, 16'd0, 16'd20);
        frames[1] = 1; wr_cyc_q.delete(); drive();
        wait_drain("zero_len", 40);
        repeat (4) tick();
        chk("zero_len_writes", 64'(wr_cyc_q.size()), 64'd0);

        // Both sources request two 8-byte frames each: grants alternate 0,1,0,1.
        req_len = {16'd8, 16'd8};
        src_q0 = '{64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00A1};
        src_q1 = '{64'h0000_0000_0000_00B0, 64'h0000_0000_0000_00B1};
        exp_wr_q = '{64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00B0,
                     64'h0000_0000_0000_00A1, 64'h0000_0000_0000_00B1};
        exp_done(2'b01, 16'd8, 16'd28); exp_done(2'b10, 16'd8, 16'd28);
        exp_done(2'b01, 16'd8, 16'd28); exp_done(2'b10, 16'd8, 16'd28);
        frames[0] = 2; frames[1] = 2; wr_cyc_q.delete(); drive();
        wait_drain("alternate", 80);
        chk("alt_writes", 64'(wr_cyc_q.size()), 64'd4);
        if (wr_cyc_q.size() == 4)
            for (int i = 1; i < 4; i++) chk("alt_spacing", 64'(wr_cyc_q[i] - wr_cyc_q[i-1]), 64'd5);
        repeat (4) tick();

        // 32-byte frame with FIFO full for 5 cycles after the 2nd word.
        req_len[15:0] = 16'd32;
        src_q0 = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
        exp_wr_q = '{64'hD0, 64'hD1, 64'hD2, 64'hD3};
        exp_done(2'b01, 16'd32, 16'd52);
        xfer_cnt = 0; frames[0] = 1; wr_cyc_q.delete(); drive();
        n = 0;
        while (xfer_cnt < 2 && n < 40) begin tick(); n++; end
        chk("full_pre_xfers", 64'(xfer_cnt), 64'd2);
        etx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("full_src_ready", 64'(src_ready), 64'd0);
            if (k > 0) chk("full_ewr_en", 64'(ewr_en), 64'd0);
            tick();
        end
        etx_full = 1'b0;
        wait_drain("backpressure", 40);
        chk("full_writes", 64'(wr_cyc_q.size()), 64'd4);
        repeat (4) tick();

        // Drop enable after 1 of 4 words on source 1: no done, back to IDLE.
        req_len[31:16] = 16'd32;
        src_q1 = '{64'hE0};
        exp_wr_q = '{64'hE0};
        xfer_cnt = 0; frames[1] = 1; drive();
        n = 0;
        while (xfer_cnt < 1 && n < 40) begin tick(); n++; end
        en = 1'b0;
        tick();
        chk("abort_ctrl", 64'({busy, grant, etx_enable, etx_fifo_rst, src_ready}), 64'd0);
        chk("abort_len_kept", 64'(tx_data_length), 64'd32);
        frames[1] = 0; src_q1.delete(); drive();
        wait_drain("abort", 10);
        repeat (3) tick();
        chk("abort_ewr_en", 64'(ewr_en), 64'd0);

        // Re-enable: passes through FLUSH, then round-robin resumes at source 1.
        en = 1'b1;
        tick();
        chk("reenable_flush", 64'({busy, etx_enable}), 64'({1'b1, 1'b0}));
        req_len = {16'd8, 16'd8};
        src_q0 = '{64'hF0}; src_q1 = '{64'hF1};
        exp_wr_q = '{64'hF1, 64'hF0};
        exp_done(2'b10, 16'd8, 16'd28); exp_done(2'b01, 16'd8, 16'd28);
        frames[0] = 1; frames[1] = 1; drive();
        wait_drain("resume", 60);
        repeat (4) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
